multicycle_controller: RTL

//  Main control FSM for the multi-cycle RV32I core variant. Sequences a single shared ALU, a unified

---
 rtl/multicycle_controller_pkg.sv | 59 +++++
 rtl/multicycle_controller_alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: FSM states, opcodes,
// datapath select codes and ALU control values.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, UTYPE, FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_UTYPE = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;

  // LUI and AUIPC differ only in op[5].
  function automatic logic is_utype(input logic [6:0] op);
    return (op[6] == 1'b0) && (op[4:0] == 5'b10111);
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU_Decoder: maps ALUOp plus instruction function fields to the 4-bit ALU operation.
module ALU_Decoder
  import mc_ctrl_pkg::*;
(
  input  logic       opb5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [1:0] alu_op,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_UTYPE: alu_control = funct3[0] ? ALU_LUI : ALU_AUIPC;
      default: begin
        case (funct3)
          3'b000:  alu_control = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RV32I core. Define MC_CTRL_PERF_CNT_EN to add
// the CycleCnt/InstRet performance counter outputs.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUControl,
  output logic             Fault
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CycleCnt,
  output logic [CNT_W-1:0] InstRet
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic mem_req, mem_write, pc_write, ir_write, reg_write, adr_src, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src, dec_funct3;
  logic mem_state, timeout;

  assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);
  assign timeout   = mem_state && !MemReady && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    fault      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (MemReady) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          result_src = RES_ALURESULT;
          state_d    = DECODE;
        end
      end
      DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          default:           state_d = is_utype(op) ? UTYPE : FAULT;
        endcase
      end
      MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = op[5] ? IMM_S : IMM_I;
        state_d   = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = FETCH;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_op    = ALUOP_FUNCT;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        imm_src   = IMM_B;
        alu_op    = ALUOP_SUB;
        // Only beq/bne are handled; any other branch flavour is treated as illegal.
        case (funct3)
          3'b000: begin pc_write = Zero;  state_d = FETCH; end
          3'b001: begin pc_write = !Zero; state_d = FETCH; end
          default: state_d = FAULT;
        endcase
      end
      JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        imm_src   = IMM_J;
        pc_write  = 1'b1;
        state_d   = ALUWB;
      end
      JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_I;
        pc_write   = 1'b1;
        result_src = RES_ALURESULT;
        state_d    = ALUWB;
      end
      UTYPE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        alu_op    = ALUOP_UTYPE;
        state_d   = ALUWB;
      end
      FAULT:   fault   = 1'b1;
      default: state_d = FAULT;
    endcase
    if (timeout) state_d = FAULT;
    wait_d = (mem_state && !MemReady) ? wait_q + WAIT_W'(1) : '0;
  end

  assign dec_funct3 = (alu_op == ALUOP_UTYPE) ? {2'b00, op[5]} : funct3;

  ALU_Decoder u_alu_decoder (
    .opb5       (op[5]),
    .funct3     (dec_funct3),
    .funct7b5   (funct7b5),
    .alu_op     (alu_op),
    .alu_control(ALUControl)
  );

  // Strobes are masked by reset directly so an access in flight is dropped immediately.
  assign MemReq    = mem_req   & ~reset;
  assign MemWrite  = mem_write & ~reset;
  assign PCWrite   = pc_write  & ~reset;
  assign IRWrite   = ir_write  & ~reset;
  assign RegWrite  = reg_write & ~reset;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ImmSrc    = imm_src;
  assign Fault     = fault;

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, inst_ret_q, inst_ret_d;
  logic retire;

  assign retire = (state_d == FETCH) && (state_q != FETCH);

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    inst_ret_d  = inst_ret_q + CNT_W'(retire);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      inst_ret_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      inst_ret_q  <= inst_ret_d;
    end
  end

  assign CycleCnt = cycle_cnt_q;
  assign InstRet  = inst_ret_q;
`endif

endmodule
